// File: rtl/id_stage_pipe.sv
// Decode stage with register file, ID/EX pipeline register, load-use bubble insertion and flush.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle writeback into the captured operands.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = $clog2(NUM_REGS),
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_ready,
  input  logic              flush,
  input  logic              wb_reg_write_en,
  input  logic [REG_AW-1:0] wb_write_addr,
  input  logic [XLEN-1:0]   wb_write_data,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_reg_data1,
  output logic [XLEN-1:0]   ex_reg_data2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs_addr,
  output logic [REG_AW-1:0] ex_rt_addr,
  output logic [REG_AW-1:0] ex_dest_addr,
  output logic [4:0]        ex_shamt,
  output logic [12:0]       ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       use_shamt;
    logic [3:0] alu;
  } ctrl_t;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR  = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_XOR = 4'b0011, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111,
                         ALU_SLL = 4'b1000, ALU_SRL = 4'b1001, ALU_SRA = 4'b1010,
                         ALU_NOR = 4'b1100;

  logic [5:0]        opcode, funct;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [XLEN-1:0]   imm_ext, rd1, rd2;
  ctrl_t             ctrl;

  assign opcode  = if_instr[31:26];
  assign funct   = if_instr[5:0];
  assign rs      = if_instr[21 +: REG_AW];
  assign rt      = if_instr[16 +: REG_AW];
  assign rd      = if_instr[11 +: REG_AW];
  assign imm_ext = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

  // Control decode
  always_comb begin
    ctrl = '0;
    case (opcode)
      6'h00: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          6'h20, 6'h21: ctrl.alu = ALU_ADD;
          6'h22, 6'h23: ctrl.alu = ALU_SUB;
          6'h24:        ctrl.alu = ALU_AND;
          6'h25:        ctrl.alu = ALU_OR;
          6'h26:        ctrl.alu = ALU_XOR;
          6'h27:        ctrl.alu = ALU_NOR;
          6'h2A:        ctrl.alu = ALU_SLT;
          6'h00: begin ctrl.alu = ALU_SLL; ctrl.use_shamt = 1'b1; end
          6'h02: begin ctrl.alu = ALU_SRL; ctrl.use_shamt = 1'b1; end
          6'h03: begin ctrl.alu = ALU_SRA; ctrl.use_shamt = 1'b1; end
          6'h08: begin ctrl.reg_dst = 1'b0; ctrl.reg_write = 1'b0; ctrl.jump = 1'b1; end
          default: begin ctrl.reg_dst = 1'b0; ctrl.reg_write = 1'b0; end
        endcase
      end
      6'h23: begin
        ctrl.alu_src = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.reg_write = 1'b1;
        ctrl.mem_read = 1'b1; ctrl.alu = ALU_ADD;
      end
      6'h2B: begin ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; ctrl.alu = ALU_ADD; end
      6'h04, 6'h05: begin ctrl.branch = 1'b1; ctrl.alu = ALU_SUB; end
      6'h08, 6'h09: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu = ALU_ADD; end
      6'h0A: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu = ALU_SLT; end
      6'h0C: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu = ALU_AND; end
      6'h0D: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu = ALU_OR;  end
      6'h0E: begin ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; ctrl.alu = ALU_XOR; end
      6'h02, 6'h03: ctrl.jump = 1'b1;
      default: ctrl = '0;
    endcase
  end

  logic [XLEN-1:0] rf_q [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_reg_write_en && wb_write_addr != '0) begin
      rf_q[wb_write_addr] <= wb_write_data;
    end
  end

`ifdef ID_WB_BYPASS_EN
  assign rd1 = (rs == '0) ? '0 : (wb_reg_write_en && wb_write_addr == rs) ? wb_write_data : rf_q[rs];
  assign rd2 = (rt == '0) ? '0 : (wb_reg_write_en && wb_write_addr == rt) ? wb_write_data : rf_q[rt];
`else
  assign rd1 = (rs == '0) ? '0 : rf_q[rs];
  assign rd2 = (rt == '0) ? '0 : rf_q[rt];
`endif

  logic              ex_valid_q;
  logic [XLEN-1:0]   ex_pc_q, ex_d1_q, ex_d2_q, ex_imm_q;
  logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_dest_q;
  logic [4:0]        ex_shamt_q;
  ctrl_t             ex_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              load_en, hazard;

  assign load_en = !ex_valid_q || ex_ready;
  // Load in EX whose destination feeds the instruction now being decoded
  assign hazard  = if_valid && ex_valid_q && ex_ctrl_q.mem_read && (ex_dest_q != '0) &&
                   ((ex_dest_q == rs) || (ex_dest_q == rt));
  assign if_ready = rst_n && (flush || (load_en && !hazard));
  assign stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_pc_q     <= '0;
      ex_d1_q     <= '0;
      ex_d2_q     <= '0;
      ex_imm_q    <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_dest_q   <= '0;
      ex_shamt_q  <= '0;
      ex_ctrl_q   <= '0;
      stall_cnt_q <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
    end else if (load_en) begin
      if (hazard) begin
        ex_valid_q  <= 1'b0;
        ex_ctrl_q   <= '0;
        stall_cnt_q <= stall_cnt_d;
      end else if (if_valid) begin
        ex_valid_q <= 1'b1;
        ex_pc_q    <= if_pc;
        ex_d1_q    <= rd1;
        ex_d2_q    <= rd2;
        ex_imm_q   <= imm_ext;
        ex_rs_q    <= rs;
        ex_rt_q    <= rt;
        ex_dest_q  <= ctrl.reg_dst ? rd : rt;
        ex_shamt_q <= if_instr[10:6];
        ex_ctrl_q  <= ctrl;
      end else begin
        ex_valid_q <= 1'b0;
        ex_ctrl_q  <= '0;
      end
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_reg_data1 = ex_d1_q;
  assign ex_reg_data2 = ex_d2_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs_addr   = ex_rs_q;
  assign ex_rt_addr   = ex_rt_q;
  assign ex_dest_addr = ex_dest_q;
  assign ex_shamt     = ex_shamt_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus random traffic against a
// transaction-level model of the ID/EX register, register file and stall counter.
module tb_id_stage_pipe;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        if_valid = 0, flush = 0, wb_reg_write_en = 0, ex_ready = 0;
  logic [31:0] if_instr = 0, if_pc = 0, wb_write_data = 0;
  logic [4:0]  wb_write_addr = 0;
  logic        if_ready, ex_valid;
  logic [31:0] ex_pc, ex_reg_data1, ex_reg_data2, ex_imm;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_dest_addr, ex_shamt;
  logic [12:0] ex_ctrl;
  logic [CNT_W-1:0] stall_cnt;

  id_stage_pipe #(.XLEN(32), .NUM_REGS(32), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .flush(flush), .wb_reg_write_en(wb_reg_write_en),
    .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_reg_data1(ex_reg_data1),
    .ex_reg_data2(ex_reg_data2), .ex_imm(ex_imm), .ex_rs_addr(ex_rs_addr),
    .ex_rt_addr(ex_rt_addr), .ex_dest_addr(ex_dest_addr), .ex_shamt(ex_shamt),
    .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs, rt, dest, shamt;
    logic [12:0] ctrl;
  } ex_t;

  ex_t         m;
  logic [31:0] mrf [32];
  int          mcnt;
  int          n_cmp = 0, n_err = 0;
  logic        rdy;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // {reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, jump, use_shamt, alu}
  function automatic logic [12:0] mk(input bit rdst, as, m2r, rw, mr, mw, br, j, sh, input logic [3:0] alu);
    return {rdst, as, m2r, rw, mr, mw, br, j, sh, alu};
  endfunction

  function automatic logic [12:0] dec(input logic [31:0] i);
    logic [12:0] r;
    r = '0;
    case (i[31:26])
      6'h00: case (i[5:0])
        6'h20, 6'h21: r = mk(1,0,0,1,0,0,0,0,0,4'h2);
        6'h22, 6'h23: r = mk(1,0,0,1,0,0,0,0,0,4'h6);
        6'h24:        r = mk(1,0,0,1,0,0,0,0,0,4'h0);
        6'h25:        r = mk(1,0,0,1,0,0,0,0,0,4'h1);
        6'h26:        r = mk(1,0,0,1,0,0,0,0,0,4'h3);
        6'h27:        r = mk(1,0,0,1,0,0,0,0,0,4'hC);
        6'h2A:        r = mk(1,0,0,1,0,0,0,0,0,4'h7);
        6'h00:        r = mk(1,0,0,1,0,0,0,0,1,4'h8);
        6'h02:        r = mk(1,0,0,1,0,0,0,0,1,4'h9);
        6'h03:        r = mk(1,0,0,1,0,0,0,0,1,4'hA);
        6'h08:        r = mk(0,0,0,0,0,0,0,1,0,4'h0);
        default:      r = '0;
      endcase
      6'h23:        r = mk(0,1,1,1,1,0,0,0,0,4'h2);
      6'h2B:        r = mk(0,1,0,0,0,1,0,0,0,4'h2);
      6'h04, 6'h05: r = mk(0,0,0,0,0,0,1,0,0,4'h6);
      6'h08, 6'h09: r = mk(0,1,0,1,0,0,0,0,0,4'h2);
      6'h0A:        r = mk(0,1,0,1,0,0,0,0,0,4'h7);
      6'h0C:        r = mk(0,1,0,1,0,0,0,0,0,4'h0);
      6'h0D:        r = mk(0,1,0,1,0,0,0,0,0,4'h1);
      6'h0E:        r = mk(0,1,0,1,0,0,0,0,0,4'h3);
      6'h02, 6'h03: r = mk(0,0,0,0,0,0,0,1,0,4'h0);
      default:      r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                        input logic [31:0] wd);
    if (a == 0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return mrf[a];
  endfunction

  task automatic model_reset();
    m = '{default: '0};
    mcnt = 0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
  endtask

  task automatic compare_outputs();
    chk("ex_valid", 64'(ex_valid), 64'(m.v));
    chk("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
    chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
    if (m.v) begin
      chk("ex_pc", 64'(ex_pc), 64'(m.pc));
      chk("ex_reg_data1", 64'(ex_reg_data1), 64'(m.d1));
      chk("ex_reg_data2", 64'(ex_reg_data2), 64'(m.d2));
      chk("ex_imm", 64'(ex_imm), 64'(m.imm));
      chk("ex_rs_addr", 64'(ex_rs_addr), 64'(m.rs));
      chk("ex_rt_addr", 64'(ex_rt_addr), 64'(m.rt));
      chk("ex_dest_addr", 64'(ex_dest_addr), 64'(m.dest));
      chk("ex_shamt", 64'(ex_shamt), 64'(m.shamt));
    end
  endtask

  // One cycle: drive at negedge, check if_ready, advance model at posedge, check outputs at negedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic er,
                      output logic rdy_o);
    ex_t nxt;
    bit  haz, le;
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl;
    wb_reg_write_en = we; wb_write_addr = wa; wb_write_data = wd; ex_ready = er;
    #1;
    haz = v && m.v && m.ctrl[8] && m.dest != 0 && (m.dest == ins[25:21] || m.dest == ins[20:16]);
    le  = !m.v || er;
    rdy_o = if_ready;
    chk("if_ready", 64'(if_ready), 64'(fl || (le && !haz)));
    nxt = m;
    if (fl) begin
      nxt.v = 0; nxt.ctrl = 0;
    end else if (le && haz) begin
      nxt.v = 0; nxt.ctrl = 0;
      if (mcnt < MAXC) mcnt++;
    end else if (le && v) begin
      nxt.v = 1; nxt.pc = pc; nxt.ctrl = dec(ins);
      nxt.rs = ins[25:21]; nxt.rt = ins[20:16]; nxt.shamt = ins[10:6];
      nxt.d1 = rdreg(ins[25:21], we, wa, wd);
      nxt.d2 = rdreg(ins[20:16], we, wa, wd);
      nxt.imm = {{16{ins[15]}}, ins[15:0]};
      nxt.dest = nxt.ctrl[12] ? ins[15:11] : ins[20:16];
    end else if (le) begin
      nxt.v = 0; nxt.ctrl = 0;
    end
    @(posedge clk);
    m = nxt;
    if (we && wa != 0) mrf[wa] = wd;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input logic er);
    logic r;
    step(0, 32'h0, 32'h0, 0, 0, 5'd0, 32'h0, er, r);
  endtask

  localparam logic [31:0] ADD_R3  = 32'h00A01820;  // add r3,r5,r0
  localparam logic [31:0] LW_R4   = 32'h8C240008;  // lw  r4,8(r1)
  localparam logic [31:0] ADD_R6  = 32'h00823020;  // add r6,r4,r2
  localparam logic [31:0] OR_R10  = 32'h01205025;  // or  r10,r9,r0
  localparam logic [31:0] OR_R8   = 32'h00E04025;  // or  r8,r7,r0
  localparam logic [31:0] OR_R8Z  = 32'h00004025;  // or  r8,r0,r0

  initial begin
    logic [31:0] ops [12];
    logic [5:0]  fns [8];
    model_reset();
    flush = 1; if_valid = 1;
    repeat (2) @(negedge clk);
    chk("reset_if_ready", 64'(if_ready), 64'(0));
    compare_outputs();
    rst_n = 1; flush = 0; if_valid = 0;
    idle(1);

    // WB r5, then add r3,r5,r0 two cycles later
    step(0, 32'h0, 32'h0, 0, 1, 5'd5, 32'h1234, 1, rdy);
    idle(1); idle(1);
    step(1, ADD_R3, 32'h100, 0, 0, 5'd0, 32'h0, 1, rdy);
    chk("add_valid", 64'(ex_valid), 64'(1));
    chk("add_data1", 64'(ex_reg_data1), 64'(32'h1234));
    chk("add_dest", 64'(ex_dest_addr), 64'(3));
    chk("add_regwrite", 64'(ex_ctrl[9]), 64'(1));
    chk("add_stall", 64'(stall_cnt), 64'(0));

    // Load-use: one bubble
    step(1, LW_R4, 32'h104, 0, 0, 5'd0, 32'h0, 1, rdy);
    step(1, ADD_R6, 32'h108, 0, 0, 5'd0, 32'h0, 1, rdy);
    chk("lu_rdy", 64'(rdy), 64'(0));
    chk("lu_bubble", 64'(ex_valid), 64'(0));
    step(1, ADD_R6, 32'h108, 0, 0, 5'd0, 32'h0, 1, rdy);
    chk("lu_issue", 64'({ex_valid, ex_dest_addr}), 64'({1'b1, 5'd6}));
    chk("lu_stall", 64'(stall_cnt), 64'(1));

    // Load-use while EX is stalled
    step(1, LW_R4, 32'h10C, 0, 0, 5'd0, 32'h0, 1, rdy);
    for (int i = 0; i < 3; i++) begin
      step(1, ADD_R6, 32'h110, 0, 0, 5'd0, 32'h0, 0, rdy);
      chk("st_rdy", 64'(rdy), 64'(0));
      chk("st_hold", 64'({ex_valid, ex_dest_addr, ex_pc}), 64'({1'b1, 5'd4, 32'h10C}));
      chk("st_cnt", 64'(stall_cnt), 64'(1));
    end
    step(1, ADD_R6, 32'h110, 0, 0, 5'd0, 32'h0, 1, rdy);
    chk("st_bubble", 64'({rdy, ex_valid, stall_cnt}), 64'({1'b0, 1'b0, 4'd2}));
    step(1, ADD_R6, 32'h110, 0, 0, 5'd0, 32'h0, 1, rdy);

    // Flush with a concurrent WB write
    step(1, LW_R4, 32'h114, 1, 1, 5'd9, 32'h5A5A, 0, rdy);
    chk("fl_rdy", 64'(rdy), 64'(1));
    chk("fl_kill", 64'({ex_valid, ex_ctrl}), 64'(0));
    step(1, OR_R10, 32'h118, 0, 0, 5'd0, 32'h0, 1, rdy);
    chk("fl_wb", 64'(ex_reg_data1), 64'(32'h5A5A));

    // Same-cycle WB and read; writes to r0
    step(1, OR_R8, 32'h11C, 0, 1, 5'd7, 32'hBEEF, 1, rdy);
`ifdef ID_WB_BYPASS_EN
    chk("byp_data1", 64'(ex_reg_data1), 64'(32'hBEEF));
`else
    chk("byp_data1", 64'(ex_reg_data1), 64'(0));
`endif
    step(0, 32'h0, 32'h0, 0, 1, 5'd0, 32'hFFFF, 1, rdy);
    step(1, OR_R8Z, 32'h120, 0, 1, 5'd0, 32'hFFFF, 1, rdy);
    chk("r0_zero", 64'(ex_reg_data1), 64'(0));

    // Saturation
    for (int i = 0; i < 17; i++) begin
      step(1, LW_R4, 32'h200, 0, 0, 5'd0, 32'h0, 1, rdy);
      step(1, ADD_R6, 32'h204, 0, 0, 5'd0, 32'h0, 1, rdy);
      step(1, ADD_R6, 32'h204, 0, 0, 5'd0, 32'h0, 1, rdy);
    end
    chk("sat", 64'(stall_cnt), 64'(4'hF));

    // Random traffic; reset first so the counter is live again
    rst_n = 0; #1; model_reset(); @(negedge clk); rst_n = 1;
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0D, 6'h0A, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h25, 6'h00, 6'h03, 6'h2A, 6'h08, 6'h3F};
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      ins[31:26] = ops[$urandom_range(0, 11)][5:0];
      ins[25:21] = 5'($urandom_range(0, 7));
      ins[20:16] = 5'($urandom_range(0, 7));
      ins[15:11] = 5'($urandom_range(0, 7));
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 31) == 0) ins = 32'h0;
      step($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 15) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) != 0, rdy);
    end

    // Asynchronous reset mid-cycle
    if_valid = 1; flush = 1;
    #2 rst_n = 0;
    #1;
    chk("areset_if_ready", 64'(if_ready), 64'(0));
    chk("areset_valid", 64'({ex_valid, ex_ctrl, stall_cnt}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
